pwm_mix_scheduler: RTL

- Sequences drum-voice sample fetches and feeds one mixed 16-bit word per sample period to the PWM output stage.
- Word format: upper byte = right-channel duty, lower byte = left-channel duty.
- Owns the audio frame timebase: a free-running frame counter mirrors the 256-cycle PWM period and derives the sample tick.
- Each sample period it polls every enabled voice over a request/valid handshake. It sums the voices per channel with saturation and presents the mix at the next sample tick.

---
 rtl/audio_pkg.sv | 26 ++
 rtl/audio_timebase.sv | 40 ++++
 rtl/pwm_mix_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio types, FSM encoding and saturating byte add for the drum mixer
// and the PWM output stage.
package audio_pkg;

   localparam int PWM_FRAME_LEN = 256;

   typedef struct packed {
      logic [7:0] right;
      logic [7:0] left;
   } stereo_sample_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_NEXT,
      ST_DONE
   } mix_state_t;

   // Channel sums are formed 9 bits wide and clamp at full scale instead of wrapping.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/audio_timebase.sv
// Frame timebase: frame_cnt mirrors the PWM period, frame_idx counts frames per
// sample; frame_start and sample_tick are decoded from the registered counters.
module audio_timebase
   import audio_pkg::*;
#(
   parameter int FRAME_LEN         = PWM_FRAME_LEN,
   parameter int FRAMES_PER_SAMPLE = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic frame_start,
   output logic sample_tick
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int IDX_W = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;

   logic [CNT_W-1:0] frame_cnt;
   logic [IDX_W-1:0] frame_idx;

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // register samples pre-edge values and ordering between always_ff blocks cannot matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         frame_idx <= '0;
      end else if (frame_cnt == CNT_W'(FRAME_LEN - 1)) begin
         frame_cnt <= '0;
         frame_idx <= (frame_idx == IDX_W'(FRAMES_PER_SAMPLE - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Qualified by rst_n so both strobes read 0 while held in reset, yet the
   // first tick is visible in the very first cycle after release.
   assign frame_start = rst_n && (frame_cnt == '0);
   assign sample_tick = frame_start && (frame_idx == '0);

endmodule

// File: rtl/pwm_mix_scheduler.sv
// Polls each enabled drum voice once per sample period over req/valid, sums the
// voices per channel with saturation and hands the mix to the PWM stage.
module pwm_mix_scheduler
   import audio_pkg::*;
#(
   parameter int NUM_VOICES        = 4,
   parameter int FRAME_LEN         = PWM_FRAME_LEN,
   parameter int FRAMES_PER_SAMPLE = 4,
   parameter int VOICE_TIMEOUT     = 16,
   parameter bit STRICT_TIMING     = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_VOICES-1:0]    voice_en,
   output logic [NUM_VOICES-1:0]    voice_req,
   input  logic [NUM_VOICES-1:0]    voice_valid,
   input  logic [NUM_VOICES*16-1:0] voice_data,
   output logic [15:0]              sample_out,
   output logic                     frame_start,
   output logic                     sample_tick,
   output logic                     underrun,
   output logic                     busy
);

   localparam int IDX_W  = $clog2(NUM_VOICES);
   localparam int TCNT_W = $clog2(VOICE_TIMEOUT);

   // STRICT_TIMING may only be cleared to exercise late-mix recovery with a short period.
   if (STRICT_TIMING) begin : g_timing_check
      if (NUM_VOICES < 2 || NUM_VOICES > 8)
         $error("pwm_mix_scheduler: NUM_VOICES must be 2..8");
      if (VOICE_TIMEOUT < 2)
         $error("pwm_mix_scheduler: VOICE_TIMEOUT must be at least 2");
      if (FRAME_LEN != PWM_FRAME_LEN)
         $error("pwm_mix_scheduler: FRAME_LEN must match the PWM counter period");
      if (NUM_VOICES * (VOICE_TIMEOUT + 2) + 2 >= FRAME_LEN * FRAMES_PER_SAMPLE)
         $error("pwm_mix_scheduler: sample period too short to poll every voice");
   end

   audio_timebase #(
      .FRAME_LEN         (FRAME_LEN),
      .FRAMES_PER_SAMPLE (FRAMES_PER_SAMPLE)
   ) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .sample_tick (sample_tick)
   );

   mix_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [TCNT_W-1:0] tcnt;
   logic [7:0]       acc_r;
   logic [7:0]       acc_l;
   stereo_sample_t   pending;
   stereo_sample_t   cur;
   logic             handshake;

   assign cur       = voice_data[16*idx +: 16];
   assign handshake = voice_req[idx] && voice_valid[idx];

   // Enable is sampled at the moment a voice's turn begins.
   function automatic logic [NUM_VOICES-1:0] req_for(input logic [IDX_W-1:0] i);
      return voice_en[i] ? (NUM_VOICES'(1) << i) : '0;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= '0;
         tcnt       <= '0;
         acc_r      <= '0;
         acc_l      <= '0;
         pending    <= '0;
         sample_out <= '0;
         voice_req  <= '0;
         underrun   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sample_tick) begin
                  sample_out <= pending;
                  acc_r      <= '0;
                  acc_l      <= '0;
                  idx        <= '0;
                  tcnt       <= '0;
                  voice_req  <= req_for('0);
                  busy       <= 1'b1;
                  state      <= ST_REQ;
               end
            end

            ST_REQ, ST_NEXT: begin
               if (sample_tick) begin
                  // Late mix: keep the old output, drop the in-flight fetch, restart at voice 0.
                  underrun  <= 1'b1;
                  acc_r     <= '0;
                  acc_l     <= '0;
                  idx       <= '0;
                  tcnt      <= '0;
                  voice_req <= req_for('0);
                  state     <= ST_REQ;
               end else if (state == ST_REQ) begin
                  if (voice_req == '0) begin
                     state <= ST_NEXT;
                  end else if (handshake) begin
                     acc_r     <= sat_add8(acc_r, cur.right);
                     acc_l     <= sat_add8(acc_l, cur.left);
                     voice_req <= '0;
                     state     <= ST_NEXT;
                  end else if (tcnt == TCNT_W'(VOICE_TIMEOUT - 1)) begin
                     underrun  <= 1'b1;
                     voice_req <= '0;
                     state     <= ST_NEXT;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end else if (idx == IDX_W'(NUM_VOICES - 1)) begin
                  state <= ST_DONE;
               end else begin
                  idx       <= idx + 1'b1;
                  tcnt      <= '0;
                  voice_req <= req_for(idx + 1'b1);
                  state     <= ST_REQ;
               end
            end

            ST_DONE: begin
               pending <= {acc_r, acc_l};
               if (sample_tick) begin
                  // The mix finished exactly on the tick: publish it directly and keep going.
                  sample_out <= {acc_r, acc_l};
                  acc_r      <= '0;
                  acc_l      <= '0;
                  idx        <= '0;
                  tcnt       <= '0;
                  voice_req  <= req_for('0);
                  state      <= ST_REQ;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               voice_req <= '0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
